// File: rtl/adc_stream_packetizer.sv
// ADC sample packetizer: decimates multi-channel ADC beats and emits fixed-size
// AXI-Stream packets through a small buffer with fully registered stream outputs.
module adc_stream_packetizer #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  input  logic                     s_valid,
  input  logic                     start,
  input  logic                     abort,
  input  logic [CNT_W-1:0]         pkt_size,
  input  logic [7:0]               decim,
  output logic [NUM_CH*DATA_W-1:0] m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int unsigned DW = NUM_CH * DATA_W;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_pkt_size;
  logic [7:0]       r_decim;
  logic [7:0]       r_dec_cnt;
  logic [CNT_W-1:0] r_push_cnt;
  logic [CNT_W-1:0] r_pop_cnt;
  logic             r_overflow;
  logic [DW-1:0]    r_mem_data [FIFO_DEPTH];
  logic             r_mem_last [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [DW-1:0]    r_tdata;
  logic             r_tlast;
  logic             r_tvalid;

  state_t           w_state_nxt;
  logic             w_start_ok;
  logic             w_flush;
  logic             w_sel;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_last;
  logic             w_final;
  logic [AW-1:0]    w_rptr_inc;
  logic [AW:0]      w_count_nxt;
  logic [DW-1:0]    w_head_data;
  logic             w_head_last;
  logic             w_head_valid;

  // Control decode, next state and next head-of-buffer selection.
  always_comb begin
    w_state_nxt  = r_state;
    w_start_ok   = (r_state == ST_IDLE) && start && !abort && (pkt_size != {CNT_W{1'b0}});
    w_flush      = abort && (r_state != ST_IDLE);
    w_sel        = (r_state == ST_RUN) && s_valid && !abort && (r_dec_cnt == 8'd0);
    w_full       = (r_count == (AW+1)'(FIFO_DEPTH));
    w_pop        = r_tvalid && m_axis_tready;
    w_push       = w_sel && (!w_full || w_pop);
    w_last       = ((r_push_cnt + CNT_W'(1)) == r_pkt_size);
    w_final      = (r_state == ST_DRAIN) && w_pop && !abort &&
                   ((r_pop_cnt + CNT_W'(1)) == r_pkt_size);
    w_rptr_inc   = r_rptr + AW'(1);
    w_count_nxt  = r_count;
    w_head_data  = r_tdata;
    w_head_last  = r_tlast;
    w_head_valid = r_tvalid;

    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_push && w_last) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (abort || w_final) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase

    // The output register always mirrors the oldest entry; bypass covers an empty buffer.
    if (w_flush) begin
      w_count_nxt  = '0;
      w_head_data  = '0;
      w_head_last  = 1'b0;
      w_head_valid = 1'b0;
    end else if (w_pop) begin
      if (r_count > (AW+1)'(1)) begin
        w_head_data  = r_mem_data[w_rptr_inc];
        w_head_last  = r_mem_last[w_rptr_inc];
        w_head_valid = 1'b1;
      end else if (w_push) begin
        w_head_data  = s_data;
        w_head_last  = w_last;
        w_head_valid = 1'b1;
      end else begin
        w_head_data  = '0;
        w_head_last  = 1'b0;
        w_head_valid = 1'b0;
      end
    end else if (r_count == (AW+1)'(0)) begin
      if (w_push) begin
        w_head_data  = s_data;
        w_head_last  = w_last;
        w_head_valid = 1'b1;
      end else begin
        w_head_data  = '0;
        w_head_last  = 1'b0;
        w_head_valid = 1'b0;
      end
    end else begin
      w_head_data  = r_tdata;
      w_head_last  = r_tlast;
      w_head_valid = r_tvalid;
    end
  end

  // State, capture counters, buffer pointers and registered stream outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_pkt_size <= '0;
      r_decim    <= 8'd0;
      r_dec_cnt  <= 8'd0;
      r_push_cnt <= '0;
      r_pop_cnt  <= '0;
      r_overflow <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_tdata    <= '0;
      r_tlast    <= 1'b0;
      r_tvalid   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_tdata  <= w_head_data;
      r_tlast  <= w_head_last;
      r_tvalid <= w_head_valid;
      if (w_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + AW'(1);
        end
        if (w_pop) begin
          r_rptr <= w_rptr_inc;
        end
      end
      if (w_start_ok) begin
        r_pkt_size <= pkt_size;
        r_decim    <= decim;
        r_dec_cnt  <= 8'd0;
        r_push_cnt <= '0;
        r_pop_cnt  <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_sel && w_full && !w_pop) begin
          r_overflow <= 1'b1;
        end
        if (w_push) begin
          r_push_cnt <= r_push_cnt + CNT_W'(1);
        end
        if (w_pop) begin
          r_pop_cnt <= r_pop_cnt + CNT_W'(1);
        end
        // Decimation phase advances on every valid sample, kept or dropped.
        if ((r_state == ST_RUN) && s_valid && !abort) begin
          if ((r_decim <= 8'd1) || (r_dec_cnt == (r_decim - 8'd1))) begin
            r_dec_cnt <= 8'd0;
          end else begin
            r_dec_cnt <= r_dec_cnt + 8'd1;
          end
        end
      end
    end
  end

  // Buffer storage needs no reset: outputs are driven only from the head register.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= s_data;
      r_mem_last[r_wptr] <= w_last;
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign busy          = (r_state != ST_IDLE);
  assign done          = w_final;
  assign overflow      = r_overflow;

endmodule
